// File: rtl/ysyx_axi_pkg.sv
// Shared AXI4 read-channel definitions: bundle widths, field offsets,
// arbiter state encoding and master index constants.
package ysyx_axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;

    // AR bundle = {id, addr, len[8], size[3], burst[2]}
    localparam int AR_W = AXI_ID_W + AXI_ADDR_W + 13;
    // R bundle  = {id, data, resp[2], last}
    localparam int R_W  = AXI_ID_W + AXI_DATA_W + 3;

    localparam int AR_BURST_LSB = 0;
    localparam int AR_SIZE_LSB  = 2;
    localparam int AR_LEN_LSB   = 5;
    localparam int AR_ADDR_LSB  = 13;
    localparam int AR_ID_LSB    = 13 + AXI_ADDR_W;

    localparam int R_LAST_BIT   = 0;
    localparam int R_RESP_LSB   = 1;
    localparam int R_DATA_LSB   = 3;
    localparam int R_ID_LSB     = 3 + AXI_DATA_W;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) with master and slave views.
interface axi_rd_arbiter_if
    import ysyx_axi_pkg::*;
#(
    parameter int AR_BITS = AR_W,
    parameter int R_BITS  = R_W
);
    logic               arvalid;
    logic               arready;
    logic [AR_BITS-1:0] ar;
    logic               rvalid;
    logic               rready;
    logic [R_BITS-1:0]  r;

    modport master (
        output arvalid, ar, rready,
        input  arready, rvalid, r
    );

    modport slave (
        input  arvalid, ar, rready,
        output arready, rvalid, r
    );
endinterface

// File: rtl/axi_arb_pick.sv
// Combinational 2-way picker. On a tie, round-robin mode grants the master
// not granted last; fixed mode always favours the LSU.
module axi_arb_pick
    import ysyx_axi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic       grant
);
    // Pick the winning master index from the current request vector
    always_comb begin
        grant = M_IFU;
        if (req == 2'b11) begin
            grant = rr_en ? ~last_grant : M_LSU;
        end else if (req[M_LSU]) begin
            grant = M_LSU;
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4 read-channel arbiter.
// A grant is held from the AR handshake until the RLAST beat completes.
// Build option AXI_RD_ARB_RR_EN: round-robin tie-break (first tie after
// reset goes to IFU); otherwise fixed priority with LSU over IFU.
//
// state | meaning
// IDLE  | no owner; arbitrate pending arvalid, nothing forwarded
// ADDR  | owner's AR forwarded to slave, waiting for AR handshake
// DATA  | slave R routed to owner until the RLAST handshake
module axi_rd_arbiter
    import ysyx_axi_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int ID_W   = AXI_ID_W
) (
    input logic          clock,
    input logic          i_rst_n,
    axi_rd_arbiter_if.slave  m0,
    axi_rd_arbiter_if.slave  m1,
    axi_rd_arbiter_if.master s
);
    localparam int AR_BW = ID_W + ADDR_W + 13;
    localparam int R_BW  = ID_W + DATA_W + 3;

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             owner_nxt;
    logic             last_grant;
    logic             rr_en;
    logic             grant;
    logic [1:0]       req;
    logic             own_arvalid;
    logic             own_rready;
    logic [AR_BW-1:0] own_ar;
    logic [R_BW-1:0]  r_beat;

    assign req         = {m1.arvalid, m0.arvalid};
    assign own_arvalid = owner ? m1.arvalid : m0.arvalid;
    assign own_ar      = owner ? m1.ar      : m0.ar;
    assign own_rready  = owner ? m1.rready  : m0.rready;
    assign r_beat      = s.r;

`ifdef AXI_RD_ARB_RR_EN
    assign rr_en = 1'b1;

    // Remember who won the last arbitration; LSU at reset so the first tie goes to IFU
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= M_LSU;
        end else if (state == IDLE && req != 2'b00) begin
            last_grant <= grant;
        end
    end
`else
    assign rr_en      = 1'b0;
    assign last_grant = M_LSU;
`endif

    axi_arb_pick u_pick (
        .req        (req),
        .last_grant (last_grant),
        .rr_en      (rr_en),
        .grant      (grant)
    );

    // State and owner registers
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            owner <= M_IFU;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Next-state and channel routing; non-owner always sees idle channels
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        s.arvalid  = 1'b0;
        s.ar       = '0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        m0.r       = '0;
        m1.r       = '0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_nxt = grant;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                s.arvalid = own_arvalid;
                s.ar      = own_ar;
                if (owner == M_LSU) begin
                    m1.arready = s.arready;
                end else begin
                    m0.arready = s.arready;
                end
                if (own_arvalid && s.arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                s.rready = own_rready;
                if (owner == M_LSU) begin
                    m1.rvalid = s.rvalid;
                    m1.r      = r_beat;
                end else begin
                    m0.rvalid = s.rvalid;
                    m0.r      = r_beat;
                end
                if (s.rvalid && own_rready && r_beat[R_LAST_BIT]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
